alu_issue_unit: RTL and testbench

// - Upstream issue stage for ALU_2bit. It buffers operation requests in a FIFO.
// - Decodes each 2-bit opcode into the alu_op/functop encoding, drives the ALU operands from registers.
// - Captures result/carry_out/borrow_out and returns them on a valid/ready response channel.
// - Turns the combinational ALU into a pipelined, back-pressurable functional unit.

---
 rtl/alu_issue_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_issue_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: FIFO-buffered issue stage wrapping the combinational ALU_2bit.
// Ports: req_* (in, valid/ready), alu_* (to/from ALU), rsp_* (out, valid/ready).
// Optional `ALU_ISSUE_STATS_EN adds stat_ops/stat_flags saturating counters.
module alu_issue_unit #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_opc,
    input  logic [1:0] req_a,
    input  logic [1:0] req_b,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic       alu_op,
    output logic [4:0] functop,
    input  logic [1:0] alu_result,
    input  logic       alu_carry_out,
    input  logic       alu_borrow_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_opc,
    output logic [1:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_borrow
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [7:0] stat_ops,
    output logic [7:0] stat_flags
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] OPC_ADD = 2'b00;
    localparam logic [1:0] OPC_SUB = 2'b01;
    localparam logic [1:0] OPC_AND = 2'b10;
    localparam logic [1:0] OPC_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_RESP
    } state_t;

    function automatic logic [4:0] decode(input logic [1:0] opc);
        logic [4:0] f;
        f = 5'b00000;
        unique case (1'b1)
            (opc == OPC_ADD): f = 5'b01000;
            (opc == OPC_SUB): f = 5'b00100;
            (opc == OPC_AND): f = 5'b00000;
            (opc == OPC_OR):  f = 5'b11000;
            default:          f = 5'b00000;
        endcase
        return f;
    endfunction

    // Request FIFO: entry = {opc, a, b}
    logic [5:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          fifo_full, fifo_empty;
    logic          push, pop;
    logic [5:0]    head;

    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    // Readiness is based on the registered count only: no pass-through when full.
    assign push       = req_valid && !fifo_full;
    assign head       = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_opc, req_a, req_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Issue FSM
    state_t     state_q, state_d;
    logic [1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic       alu_op_q, alu_op_d;
    logic [4:0] functop_q, functop_d;
    logic [1:0] op_q, op_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [1:0] rsp_opc_q, rsp_opc_d;
    logic [1:0] rsp_result_q, rsp_result_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_borrow_q, rsp_borrow_d;

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        functop_d    = functop_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_opc_d    = rsp_opc_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_borrow_d = rsp_borrow_q;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    alu_a_d   = head[3:2];
                    alu_b_d   = head[1:0];
                    functop_d = decode(head[5:4]);
                    op_d      = head[5:4];
                    alu_op_d  = 1'b1;
                    state_d   = S_DRIVE;
                end
            end
            S_DRIVE: begin
                rsp_opc_d    = op_q;
                rsp_result_d = alu_result;
                rsp_carry_d  = (op_q == OPC_ADD) && alu_carry_out;
                rsp_borrow_d = (op_q == OPC_SUB) && alu_borrow_out;
                rsp_valid_d  = 1'b1;
                alu_op_d     = 1'b0;
                functop_d    = 5'b00000;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        alu_a_d   = head[3:2];
                        alu_b_d   = head[1:0];
                        functop_d = decode(head[5:4]);
                        op_d      = head[5:4];
                        alu_op_d  = 1'b1;
                        state_d   = S_DRIVE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 1'b0;
            functop_q    <= '0;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_opc_q    <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_borrow_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            functop_q    <= functop_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_opc_q    <= rsp_opc_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_borrow_q <= rsp_borrow_d;
        end
    end

    assign req_ready  = !fifo_full;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign functop    = functop_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_opc    = rsp_opc_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_borrow = rsp_borrow_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [7:0] stat_ops_q, stat_flags_q;
    logic       rsp_fire;

    assign rsp_fire = rsp_valid_q && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q   <= '0;
            stat_flags_q <= '0;
        end else if (rsp_fire) begin
            if (stat_ops_q != 8'hFF) stat_ops_q <= stat_ops_q + 1'b1;
            if ((rsp_carry_q || rsp_borrow_q) && (stat_flags_q != 8'hFF))
                stat_flags_q <= stat_flags_q + 1'b1;
        end
    end

    assign stat_ops   = stat_ops_q;
    assign stat_flags = stat_flags_q;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: scoreboard bench for alu_issue_unit with a behavioural ALU_2bit.
// Stimulus pushes expected responses/ALU drive values; negedge monitors pop and compare.
module tb_alu_issue_unit;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_opc, req_a, req_b;
    logic [1:0] alu_a, alu_b;
    logic       alu_op;
    logic [4:0] functop;
    logic [1:0] alu_result;
    logic       alu_carry_out, alu_borrow_out;
    logic       rsp_valid, rsp_ready;
    logic [1:0] rsp_opc, rsp_result;
    logic       rsp_carry, rsp_borrow;
`ifdef ALU_ISSUE_STATS_EN
    logic [7:0] stat_ops, stat_flags;
`endif

    int tests = 0;
    int fails = 0;

    logic [5:0] sb_q  [$];
    logic [8:0] drv_q [$];

    alu_issue_unit #(.FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opc        (req_opc),
        .req_a          (req_a),
        .req_b          (req_b),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_op         (alu_op),
        .functop        (functop),
        .alu_result     (alu_result),
        .alu_carry_out  (alu_carry_out),
        .alu_borrow_out (alu_borrow_out),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_opc        (rsp_opc),
        .rsp_result     (rsp_result),
        .rsp_carry      (rsp_carry),
        .rsp_borrow     (rsp_borrow)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_ops       (stat_ops),
        .stat_flags     (stat_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU_2bit model; flags are always computed so the unit must mask them.
    always_comb begin
        logic [2:0] sum;
        sum            = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry_out  = sum[2];
        alu_borrow_out = (alu_a < alu_b);
        case (functop)
            5'b01000: alu_result = sum[1:0];
            5'b00100: alu_result = alu_a - alu_b;
            5'b00000: alu_result = alu_a & alu_b;
            5'b11000: alu_result = alu_a | alu_b;
            default:  alu_result = 2'b00;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [4:0] fexp(input logic [1:0] opc);
        case (opc)
            2'b00:   return 5'b01000;
            2'b01:   return 5'b00100;
            2'b10:   return 5'b00000;
            default: return 5'b11000;
        endcase
    endfunction

    // Called just after a posedge; returns #1 after the accepting edge.
    task automatic push_req(input logic [1:0] opc, input logic [1:0] a,
                            input logic [1:0] b, input logic [1:0] er,
                            input logic ec, input logic eb);
        int n;
        n         = 0;
        req_valid = 1'b1;
        req_opc   = opc;
        req_a     = a;
        req_b     = b;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: req_ready stuck 0, expected 1");
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            sb_q.push_back({opc, er, ec, eb});
            drv_q.push_back({a, b, fexp(opc)});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || drv_q.size() != 0 || rsp_valid) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_done", (n < 2000) ? 1 : 0, 1);
    endtask

    // Response scoreboard + stall stability + ALU drive monitor.
    logic       hold;
    logic [5:0] held;
    initial hold = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) chk("rsp_stable", {rsp_opc, rsp_result, rsp_carry, rsp_borrow}, held);
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got %b with none expected",
                             {rsp_opc, rsp_result, rsp_carry, rsp_borrow});
                end else begin
                    chk("rsp_data", {rsp_opc, rsp_result, rsp_carry, rsp_borrow},
                        sb_q.pop_front());
                end
            end
            hold = rsp_valid && !rsp_ready;
            held = {rsp_opc, rsp_result, rsp_carry, rsp_borrow};
            if (alu_op) begin
                if (drv_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL drv_unexpected: alu_op=1 with no op expected");
                end else begin
                    chk("alu_drive", {alu_a, alu_b, functop}, drv_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic stale;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_opc   = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_functop", functop, 0);
        chk("rst_alu_ab", {alu_a, alu_b}, 0);
        chk("rst_rsp_data", {rsp_opc, rsp_result, rsp_carry, rsp_borrow}, 0);
`ifdef ALU_ISSUE_STATS_EN
        chk("rst_stats", {stat_ops, stat_flags}, 0);
`endif
        // Latency: accept at k, DRIVE after k+1, rsp_valid after k+2
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        push_req(2'b00, 2'b01, 2'b01, 2'b10, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_k_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("lat_k1_alu_op", alu_op, 1);
        chk("lat_k1_functop", functop, 5'b01000);
        chk("lat_k1_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("lat_k2_rsp_valid", rsp_valid, 1);
        @(posedge clk);
        #1;
        // Directed vectors, back to back
        push_req(2'b00, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0);
        push_req(2'b00, 2'b01, 2'b10, 2'b11, 1'b0, 1'b0);
        push_req(2'b01, 2'b10, 2'b01, 2'b01, 1'b0, 1'b0);
        push_req(2'b01, 2'b01, 2'b10, 2'b11, 1'b0, 1'b1);
        push_req(2'b01, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0);
        push_req(2'b10, 2'b11, 2'b10, 2'b10, 1'b0, 1'b0);
        push_req(2'b11, 2'b01, 2'b10, 2'b11, 1'b0, 1'b0);
        drain();
        // Back-pressure: 5 requests with rsp_ready low
        rsp_ready = 1'b0;
        push_req(2'b00, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0);
        push_req(2'b01, 2'b11, 2'b01, 2'b10, 1'b0, 1'b0);
        push_req(2'b10, 2'b01, 2'b11, 2'b01, 1'b0, 1'b0);
        push_req(2'b11, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0);
        push_req(2'b00, 2'b10, 2'b11, 2'b01, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("full_req_ready", req_ready, 0);
        chk("full_rsp_valid", rsp_valid, 1);
        // Push while full on the cycle a pop frees a slot
        req_valid = 1'b1;
        req_opc   = 2'b01;
        req_a     = 2'b00;
        req_b     = 2'b01;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("push_refused_full", req_ready, 0);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("ready_after_pop", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sb_q.push_back({2'b01, 2'b11, 1'b0, 1'b1});
        drv_q.push_back({2'b00, 2'b01, 5'b00100});
        repeat (4) @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain();
        // Reset while in DRIVE with 2 queued
        rsp_ready = 1'b0;
        push_req(2'b00, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0);
        push_req(2'b00, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0);
        push_req(2'b01, 2'b00, 2'b01, 2'b11, 1'b0, 1'b1);
        push_req(2'b11, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_in_drive", alu_op, 1);
        rst_n = 1'b0;
        sb_q.delete();
        drv_q.delete();
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_alu_op", alu_op, 0);
        chk("midrst_req_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        stale = 1'b0;
        repeat (10) begin
            @(negedge clk);
            stale = stale | rsp_valid | alu_op;
        end
        chk("no_stale_rsp", stale, 0);
`ifdef ALU_ISSUE_STATS_EN
        chk("midrst_stats", {stat_ops, stat_flags}, 0);
`endif
        @(posedge clk);
        #1;
        push_req(2'b00, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0);
        push_req(2'b10, 2'b11, 2'b10, 2'b10, 1'b0, 1'b0);
        push_req(2'b11, 2'b01, 2'b10, 2'b11, 1'b0, 1'b0);
        drain();
`ifdef ALU_ISSUE_STATS_EN
        chk("stat_ops_3", stat_ops, 3);
        chk("stat_flags_1", stat_flags, 1);
        for (int i = 0; i < 300; i++)
            push_req(2'b10, 2'b11, 2'b11, 2'b11, 1'b0, 1'b0);
        drain();
        chk("stat_ops_sat", stat_ops, 255);
        chk("stat_flags_hold", stat_flags, 1);
`endif
        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
